// File: rtl/alu_issue_ctrl.sv
// Issue/writeback scheduler for the lane ALU: one result per cycle reaches the RF write port.
// Latency: issue is combinational; results return 1 / MUL_LAT / FMA_LAT cycles after accept.
// Backpressure: in_ready drops when the op's writeback slot is already claimed, or on flush/reset.
module alu_issue_ctrl #(
    parameter int MICROOP_BIT = 9,
    parameter int TAG_W       = 5,
    parameter int MUL_LAT     = 2,
    parameter int FMA_LAT     = 4,
    parameter int CNT_W       = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MICROOP_BIT-1:0] in_alu_op,
    input  logic [1:0]             in_class,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic                   flush,
    output logic                   alu_valid,
    output logic [MICROOP_BIT-1:0] alu_op,
    output logic                   wb_valid,
    output logic [TAG_W-1:0]       wb_tag,
    output logic [1:0]             wb_class,
    output logic [CNT_W-1:0]       inflight,
    output logic                   idle
);

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic [1:0]       cls;
    } slot_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // s[1] is the writeback stage; the stage beyond s[FMA_LAT] is implicitly empty
    slot_t s [1:FMA_LAT];

    int    lat;
    logic  slot_busy;
    logic  accept;
    slot_t issue_slot;

    always_comb begin
        lat = 1;
        case (in_class)
            2'b01:   lat = MUL_LAT;
            2'b10:   lat = FMA_LAT;
            default: lat = 1;
        endcase
    end

    // An op landing in s[L] collides with whatever is about to shift down from s[L+1]
    always_comb begin
        slot_busy = 1'b0;
        for (int i = 2; i <= FMA_LAT; i++) begin
            if (i == lat + 1) slot_busy = s[i].vld;
        end
    end

    always_comb begin
        issue_slot.vld = 1'b1;
        issue_slot.tag = in_tag;
        issue_slot.cls = (in_class == 2'b11) ? 2'b00 : in_class;
    end

    assign in_ready  = !rst && !flush && !slot_busy;
    assign accept    = in_valid && in_ready;
    assign alu_valid = accept;
    assign alu_op    = in_alu_op;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 1; i <= FMA_LAT; i++) s[i] <= '0;
            inflight <= '0;
        end else begin
            for (int i = 1; i < FMA_LAT; i++) s[i] <= s[i+1];
            s[FMA_LAT] <= '0;
            for (int i = 1; i <= FMA_LAT; i++) begin
                if (accept && i == lat) s[i] <= issue_slot;
            end
            if (accept && !s[1].vld)
                inflight <= inflight + CNT_ONE;
            else if (!accept && s[1].vld)
                inflight <= inflight - CNT_ONE;
        end
    end

    assign wb_valid = s[1].vld;
    assign wb_tag   = s[1].tag;
    assign wb_class = s[1].cls;
    assign idle     = (inflight == '0);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: stimulus queues expected writebacks, a negedge monitor checks them.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] in_alu_op = '0;
    logic [1:0] in_class = '0;
    logic [4:0] in_tag = '0;
    logic       flush = 1'b0;
    logic       alu_valid;
    logic [8:0] alu_op;
    logic       wb_valid;
    logic [4:0] wb_tag;
    logic [1:0] wb_class;
    logic [2:0] inflight;
    logic       idle;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [4:0] tag;
        logic [1:0] cls;
        int         due;
    } exp_t;
    exp_t q[$];

    alu_issue_ctrl #(
        .MICROOP_BIT(9), .TAG_W(5), .MUL_LAT(2), .FMA_LAT(4), .CNT_W(3)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_class(in_class), .in_tag(in_tag), .flush(flush),
        .alu_valid(alu_valid), .alu_op(alu_op), .wb_valid(wb_valid), .wb_tag(wb_tag),
        .wb_class(wb_class), .inflight(inflight), .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [4:0] tag, input logic [1:0] cls, input int due);
        exp_t e;
        int   idx;
        e.tag = tag;
        e.cls = cls;
        e.due = due;
        idx = q.size();
        for (int j = 0; j < q.size(); j++) begin
            if (q[j].due > due) begin
                idx = j;
                break;
            end
        end
        q.insert(idx, e);
    endtask

    // Results still due after a flush/reset edge must never appear
    task automatic drop_future();
        for (int j = q.size() - 1; j >= 0; j--) begin
            if (q[j].due > cyc) q.delete(j);
        end
    endtask

    // One cycle: offer an op, check in_ready against exp_rdy (-1 skips), queue its writeback at +lat
    task automatic op(input logic v, input logic [1:0] cls, input logic [4:0] tag,
                      input int exp_rdy, input int lat);
        in_valid  = v;
        in_class  = cls;
        in_tag    = tag;
        in_alu_op = {2'b10, cls, tag};
        #1;
        if (exp_rdy >= 0) begin
            chk("in_ready", int'(in_ready), exp_rdy);
            if (v) begin
                chk("alu_valid", int'(alu_valid), exp_rdy);
                chk("alu_op", int'(alu_op), int'({2'b10, cls, tag}));
            end
        end
        if (v && exp_rdy == 1)
            push_exp(tag, (cls == 2'b11) ? 2'b00 : cls, cyc + lat);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int k = 0; k < n; k++) op(1'b0, 2'b00, 5'd0, -1, 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (wb_valid === 1'b1) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL wb_unexpected: got tag %0d, expected no writeback (cycle %0d)", wb_tag, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("wb_cycle", cyc, e.due);
                    chk("wb_tag", int'(wb_tag), int'(e.tag));
                    chk("wb_class", int'(wb_class), int'(e.cls));
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                exp_t e;
                e = q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL wb_missing: got no writeback, expected tag %0d due cycle %0d (cycle %0d)", e.tag, e.due, cyc);
            end
        end
    end

    initial begin
        // Reset held two edges with an op offered
        in_valid = 1'b1;
        in_class = 2'b00;
        @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_alu_valid", int'(alu_valid), 0);
        chk("rst_wb_valid", int'(wb_valid), 0);
        chk("rst_wb_tag", int'(wb_tag), 0);
        chk("rst_inflight", int'(inflight), 0);
        chk("rst_idle", int'(idle), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        mon_en = 1'b1;

        // Int stream: one in flight in steady state
        for (int i = 0; i < 8; i++) begin
            if (i > 0) chk("int_inflight", int'(inflight), 1);
            op(1'b1, 2'b00, 5'(i), 1, 1);
        end
        chk("int_inflight_tail", int'(inflight), 1);
        gap(1);
        chk("int_inflight_done", int'(inflight), 0);
        chk("int_idle_done", int'(idle), 1);

        // mul then int one cycle later: int stalls exactly one cycle
        op(1'b1, 2'b01, 5'd3, 1, 2);
        op(1'b1, 2'b00, 5'd4, 0, 0);
        op(1'b1, 2'b00, 5'd4, 1, 1);
        gap(2);

        // Out-of-order: int overtakes fma
        op(1'b1, 2'b10, 5'd1, 1, 4);
        op(1'b1, 2'b00, 5'd2, 1, 1);
        chk("ooo_inflight_peak", int'(inflight), 2);
        gap(1);
        chk("ooo_inflight_mid", int'(inflight), 1);
        gap(3);
        chk("ooo_inflight_end", int'(inflight), 0);

        // fma then mul two cycles later collides
        op(1'b1, 2'b10, 5'd5, 1, 4);
        gap(1);
        op(1'b1, 2'b01, 5'd6, 0, 0);
        op(1'b1, 2'b01, 5'd6, 1, 2);
        gap(3);

        // Flush with an op offered: it is dropped along with everything in flight
        op(1'b1, 2'b10, 5'd8, 1, 4);
        op(1'b1, 2'b01, 5'd9, 1, 2);
        flush = 1'b1;
        drop_future();
        op(1'b1, 2'b00, 5'd10, 0, 0);
        flush = 1'b0;
        chk("flush_inflight", int'(inflight), 0);
        chk("flush_idle", int'(idle), 1);
        gap(4);

        // Class 11 behaves as int and reports class 00
        op(1'b1, 2'b11, 5'd11, 1, 1);
        gap(2);

        // Reset mid-operation kills the in-flight fma
        op(1'b1, 2'b10, 5'd12, 1, 4);
        rst = 1'b1;
        drop_future();
        op(1'b1, 2'b00, 5'd13, 0, 0);
        rst = 1'b0;
        chk("rst_mid_inflight", int'(inflight), 0);
        gap(4);

        // Same-class back-to-back never collides
        op(1'b1, 2'b01, 5'd14, 1, 2);
        op(1'b1, 2'b01, 5'd15, 1, 2);
        op(1'b1, 2'b10, 5'd16, 1, 4);
        op(1'b1, 2'b10, 5'd17, 1, 4);
        gap(6);
        chk("final_inflight", int'(inflight), 0);

        for (int k = 0; k < 20 && q.size() > 0; k++) gap(1);
        chk("scoreboard_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue and writeback scheduler for the vector lane ALU. It accepts micro-ops from the lane's operand-read stage over a valid/ready handshake and drives the ALU's `alu_op` strobe. It tracks the differing result latencies of the integer, multiplier and FMA paths, and guarantees that at most one result reaches the lane register-file write port per cycle. It also returns each result's tag, class and in-flight occupancy to the lane sequencer.

## Interface
Parameters:
- `MICROOP_BIT`, 9: micro-op width, same as the ALU.
- `TAG_W`, 5: destination/instruction tag width.
- `MUL_LAT`, 2: multiplier result latency in cycles; legal range 2..FMA_LAT.
- `FMA_LAT`, 4: FMA result latency in cycles; must be ≥ MUL_LAT.
- `CNT_W`, 3: in-flight counter width; must hold FMA_LAT.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `in_valid`, in, 1: micro-op offered.
- `in_ready`, out, 1: micro-op accepted this cycle when high together with `in_valid`.
- `in_alu_op`, in, MICROOP_BIT: micro-op code.
- `in_class`, in, 2: latency class. 00 int (latency 1), 01 mul (MUL_LAT), 10 fma (FMA_LAT), 11 treated as int.
- `in_tag`, in, TAG_W: tag returned with the result.
- `flush`, in, 1: kill all in-flight ops.
- `alu_valid`, out, 1: issue strobe to the ALU, equal to `in_valid & in_ready`.
- `alu_op`, out, MICROOP_BIT: `in_alu_op` passthrough.
- `wb_valid`, out, 1: ALU result is valid this cycle.
- `wb_tag`, out, TAG_W: tag of the result.
- `wb_class`, out, 2: class of the result (11 is reported as 00).
- `inflight`, out, CNT_W: count of issued ops not yet written back.
- `idle`, out, 1: `inflight == 0`.

## Operation
- **Slot tracker.** Stages s[1..FMA_LAT] each hold {valid, tag, class}. Stage s[FMA_LAT+1] is constant empty.
- **Shift.** Every edge: s[i] <= s[i+1] for i = 1..FMA_LAT.
- **Issue.** An accepted op of latency L is written into s[L] on the same edge. This write overrides the shift into s[L]. That shift is necessarily empty, because `in_ready` guarantees it.
- **Ready rule.** `in_ready = !rst & !flush & !s[L+1].valid`, where L is the latency of the offered `in_class`. `in_ready` is combinational from `in_class` and the tracker, and does not depend on `in_valid`.
- **Writeback.** `wb_valid/wb_tag/wb_class` come straight from s[1] (registered outputs). An op accepted in cycle T writes back in cycle T+L.
- **Ordering.** Results may complete out of order. Example: int issued after fma completes first. Consumers reorder by tag; this block only prevents write-port collision.
- **Counter.** `inflight` += 1 on accept and −= 1 on `wb_valid`. Simultaneous accept and writeback leaves it unchanged. It never wraps, by construction, because there is at most one op per stage.
- **Flush.** On the edge where `flush` is high, all s[*].valid <= 0 and `inflight` <= 0.
  - `in_ready` is 0 in the flush cycle, so nothing is accepted.
  - `wb_valid` in the flush cycle still reflects s[1]. That result is legal and the consumer decides whether to take it.
- **No writeback backpressure.** The register-file port always accepts.

## Timing
- **Reset values.**
  - `rst` high on an edge clears all stages and `inflight`.
  - `wb_valid` = 0, `wb_tag` = 0, `wb_class` = 0, `inflight` = 0, `idle` = 1.
  - `in_ready` and `alu_valid` are 0 while `rst` is high.
- **Reset mid-operation** behaves as flush: in-flight results are never reported afterwards.
- **Issue latency.** Zero cycles: `alu_valid` and `alu_op` are combinational from the accept.
- **Result latency.** 1 / MUL_LAT / FMA_LAT cycles from accept to `wb_valid`.
- **Throughput.** One op per cycle if classes do not collide. Same-class back-to-back ops never collide.
- **Collision.** An op of latency L offered at T+k after an op of latency L+k accepted at T stalls for exactly one cycle.
- **Simultaneous events.**
  - Accept into s[L] plus shift of s[L+1]: impossible, because `in_ready` is low.
  - Flush plus `in_valid`: op is dropped (not accepted).
  - `rst` plus `flush`: same effect as `rst`.

## Test plan
- **Reset:** hold `rst` 2 cycles with `in_valid`=1 → `in_ready`=0, `wb_valid`=0, `inflight`=0, `idle`=1.
- **Int stream:** 8 int ops, tags 0..7, on consecutive cycles → all accepted, `wb_tag` 0..7 on cycles T+1..T+8, `inflight` stays 1.
- **Collision:** mul tag 3 at T, int tag 4 offered at T+1 → `in_ready`=0 at T+1, int accepted at T+2. `wb_tag`=3 at T+2 and `wb_tag`=4 at T+3.
- **Out-of-order:** fma tag 1 at T, int tag 2 at T+1 → `wb_tag` 2 at T+2, `wb_tag` 1 at T+4, `inflight` peaks at 2.
- **Flush:** fma at T, mul at T+1, `flush` at T+2 → no `wb_valid` at T+3..T+4, `inflight`=0 and `idle`=1 at T+3.
- **Class 11:** offered at T → treated as int, writes back at T+1 with `wb_class`=00.
